// File: rtl/prbs9_pkg.sv
// prbs9_pkg: shared types and constants for the PRBS9 (x^9 + x^5 + 1)
// checker family.
package prbs9_pkg;

  // Checker acquisition states.
  typedef enum logic [1:0] {
    FILL,
    HUNT,
    LOCKED
  } prbs9_state_e;

  // Register length and feedback taps: bit[n] = bit[n-9] ^ bit[n-5].
  localparam int unsigned PRBS9_LEN   = 9;
  localparam int unsigned PRBS9_TAP_A = 8;
  localparam int unsigned PRBS9_TAP_B = 4;

  // Default lock/loss tuning.
  localparam int unsigned PRBS9_LOCK_CNT_DEF = 16;
  localparam int unsigned PRBS9_LOSS_WIN_DEF = 64;
  localparam int unsigned PRBS9_LOSS_THR_DEF = 8;

  // Next PRBS9 bit predicted from the current shift register contents.
  function automatic logic prbs9_predict(input logic [PRBS9_LEN-1:0] sr);
    return sr[PRBS9_TAP_A] ^ sr[PRBS9_TAP_B];
  endfunction

endpackage

// File: rtl/prbs9_err_window.sv
// prbs9_err_window: loss-of-lock observation window. Counts valid bits and
// errors inside a LOSS_WIN-bit window and raises a combinational 'loss'
// strobe on the bit that brings the window error count to LOSS_THR.
module prbs9_err_window
  import prbs9_pkg::*;
#(
  parameter int unsigned LOSS_WIN = PRBS9_LOSS_WIN_DEF,
  parameter int unsigned LOSS_THR = PRBS9_LOSS_THR_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic step,
  input  logic err,
  output logic loss
);

  localparam int unsigned WIN_W = (LOSS_WIN > 1) ? $clog2(LOSS_WIN + 1) : 1;
  localparam int unsigned THR_W = (LOSS_THR > 1) ? $clog2(LOSS_THR + 1) : 1;

  logic [WIN_W-1:0] win_q, win_d, win_inc;
  logic [THR_W-1:0] werr_q, werr_d, werr_inc;
  logic             win_end;

  // Window bookkeeping: a loss or a completed window both restart counting.
  always_comb begin
    win_inc  = win_q + WIN_W'(1);
    werr_inc = werr_q + THR_W'(err);
    loss     = step && (werr_inc >= THR_W'(LOSS_THR));
    win_end  = step && (win_inc == WIN_W'(LOSS_WIN));
    win_d    = win_q;
    werr_d   = werr_q;
    if (clear) begin
      win_d  = '0;
      werr_d = '0;
    end else if (step) begin
      if (loss || win_end) begin
        win_d  = '0;
        werr_d = '0;
      end else begin
        win_d  = win_inc;
        werr_d = werr_inc;
      end
    end
  end

  // Window counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q  <= '0;
      werr_q <= '0;
    end else begin
      win_q  <= win_d;
      werr_q <= werr_d;
    end
  end

endmodule

// File: rtl/prbs9_checker.sv
// prbs9_checker: self-synchronising PRBS9 checker. Fills a 9-bit register
// from the line, hunts for LOCK_CNT consecutive correct predictions, then
// free-runs its own sequence while LOCKED and flags each mismatching bit.
// Optional BER counters are built when PRBS9_CHK_BER_CNT_EN is defined;
// otherwise o_bit_cnt/o_err_cnt are tied to zero.
module prbs9_checker
  import prbs9_pkg::*;
#(
  parameter int unsigned LOCK_CNT = PRBS9_LOCK_CNT_DEF,
  parameter int unsigned LOSS_WIN = PRBS9_LOSS_WIN_DEF,
  parameter int unsigned LOSS_THR = PRBS9_LOSS_THR_DEF,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_bit,
  input  logic             i_valid,
  output logic             o_locked,
  output logic             o_err,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int unsigned FILL_W  = $clog2(PRBS9_LEN);
  localparam int unsigned MATCH_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;

  prbs9_state_e         state_q, state_d;
  logic [PRBS9_LEN-1:0] sr_q, sr_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic                 err_q, err_d;
  logic                 locked_q, locked_d;

  logic pred;
  logic mism;
  logic win_clear;
  logic win_step;
  logic win_err;
  logic win_loss;

  prbs9_err_window #(
    .LOSS_WIN (LOSS_WIN),
    .LOSS_THR (LOSS_THR)
  ) u_err_window (
    .clk   (clk),
    .rst   (rst),
    .clear (win_clear),
    .step  (win_step),
    .err   (win_err),
    .loss  (win_loss)
  );

  // Next-state logic; nothing moves unless i_valid qualifies the bit.
  always_comb begin
    pred      = prbs9_predict(sr_q);
    mism      = i_bit ^ pred;
    state_d   = state_q;
    sr_d      = sr_q;
    fill_d    = fill_q;
    match_d   = match_q;
    err_d     = 1'b0;
    win_clear = 1'b0;
    win_step  = 1'b0;
    win_err   = 1'b0;
    if (i_valid) begin
      unique case (state_q)
        FILL: begin
          sr_d = {sr_q[PRBS9_LEN-2:0], i_bit};
          if (fill_q == FILL_W'(PRBS9_LEN - 1)) begin
            state_d = HUNT;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        HUNT: begin
          sr_d = {sr_q[PRBS9_LEN-2:0], i_bit};
          // An all-zero register predicts zero forever; never count it.
          if (!mism && (sr_q != '0)) begin
            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d   = LOCKED;
              match_d   = '0;
              win_clear = 1'b1;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so one line error gives one o_err.
          sr_d     = {sr_q[PRBS9_LEN-2:0], pred};
          err_d    = mism;
          win_step = 1'b1;
          win_err  = mism;
          if (win_loss) begin
            state_d = FILL;
            fill_d  = '0;
          end
        end
        default: begin
          state_d = FILL;
          fill_d  = '0;
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  // Acquisition state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      sr_q     <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign o_locked = locked_q;
  assign o_err    = err_q;

`ifdef PRBS9_CHK_BER_CNT_EN
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating BER counters, advanced only by valid bits checked in LOCKED.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    if (i_valid && (state_q == LOCKED)) begin
      if (bit_cnt_q != '1) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
      if (mism && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  // BER counter registers; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_bit_cnt = bit_cnt_q;
  assign o_err_cnt = err_cnt_q;
`else
  assign o_bit_cnt = '0;
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_prbs9_checker.sv
// tb_prbs9_checker: directed scenarios plus a randomized run of prbs9_checker
// against a bit-history reference model.
module tb_prbs9_checker;

  localparam int unsigned LOCK_CNT = 16;
  localparam int unsigned LOSS_WIN = 64;
  localparam int unsigned LOSS_THR = 8;
  localparam int unsigned CNT_W    = 10;
  localparam longint      MAXC     = (longint'(1) << CNT_W) - 1;

  localparam int M_FILL   = 0;
  localparam int M_HUNT   = 1;
  localparam int M_LOCKED = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_bit = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_locked;
  logic             o_err;
  logic [CNT_W-1:0] o_bit_cnt;
  logic [CNT_W-1:0] o_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prbs9_checker #(
    .LOCK_CNT (LOCK_CNT),
    .LOSS_WIN (LOSS_WIN),
    .LOSS_THR (LOSS_THR),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_bit     (i_bit),
    .i_valid   (i_valid),
    .o_locked  (o_locked),
    .o_err     (o_err),
    .o_bit_cnt (o_bit_cnt),
    .o_err_cnt (o_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bit history, with the checker's rules applied to it.
  int     m_mode;
  bit     hist[$];
  int     m_fill, m_match, m_win, m_werr;
  longint m_bits, m_errs;
  bit     m_err;

  function automatic longint exp_cnt(input longint v);
`ifdef PRBS9_CHK_BER_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = M_FILL;
    hist.delete();
    for (int i = 0; i < 9; i++) hist.push_back(1'b0);
    m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_bits = 0; m_errs = 0; m_err = 1'b0;
  endtask

  task automatic push(input bit b);
    hist.push_back(b);
    void'(hist.pop_front());
  endtask

  task automatic model_step(input bit b);
    bit p, zero;
    p = hist[0] ^ hist[4];   // bit[n-9] ^ bit[n-5]
    m_err = 1'b0;
    case (m_mode)
      M_FILL: begin
        push(b);
        m_fill++;
        if (m_fill == 9) begin m_mode = M_HUNT; m_match = 0; end
      end
      M_HUNT: begin
        zero = 1'b1;
        foreach (hist[i]) if (hist[i]) zero = 1'b0;
        if (b == p && !zero) m_match++; else m_match = 0;
        push(b);
        if (m_match == LOCK_CNT) begin m_mode = M_LOCKED; m_win = 0; m_werr = 0; end
      end
      default: begin
        m_err = (b != p);
        push(p);
        if (m_bits < MAXC) m_bits++;
        if (m_err && m_errs < MAXC) m_errs++;
        m_win++;
        if (m_err) m_werr++;
        if (m_werr >= LOSS_THR) begin
          m_mode = M_FILL; m_fill = 0;
        end else if (m_win == LOSS_WIN) begin
          m_win = 0; m_werr = 0;
        end
      end
    endcase
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".locked"}, 32'(o_locked), 32'(m_mode == M_LOCKED));
    check({tag, ".err"}, 32'(o_err), 32'(m_err));
    check({tag, ".bit_cnt"}, 32'(o_bit_cnt), 32'(exp_cnt(m_bits)));
    check({tag, ".err_cnt"}, 32'(o_err_cnt), 32'(exp_cnt(m_errs)));
  endtask

  // Reference PRBS9 source.
  logic [8:0] gen = 9'b010101011;
  function automatic bit gen_next();
    bit nb;
    nb  = gen[8] ^ gen[4];
    gen = {gen[7:0], nb};
    return nb;
  endfunction

  task automatic drive(input bit b, input bit v);
    @(negedge clk);
    i_bit   = b;
    i_valid = v;
    @(posedge clk);
    if (v) model_step(b);
    else m_err = 1'b0;
    #1;
    compare_all("cyc");
  endtask

  task automatic send(input bit v, input bit flip);
    if (v) drive(gen_next() ^ flip, 1'b1);
    else drive(1'($urandom), 1'b0);
  endtask

  task automatic do_reset(input bit v);
    @(negedge clk);
    rst     = 1'b1;
    i_valid = v;
    i_bit   = 1'($urandom);
    @(posedge clk);
    model_reset();
    #1;
    compare_all("rst");
    @(negedge clk);
    rst     = 1'b0;
    i_valid = 1'b0;
  endtask

  // Sends clean valid bits until o_locked rises; returns the bit count.
  task automatic lock_up(output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      send(1'b1, 1'b0);
      if (o_locked && n == 0) n = i;
      if (n != 0) break;
    end
  endtask

  initial begin
    int n, pulses, vcnt;
    model_reset();

    // Reset values.
    do_reset(1'b0);
    check("reset.locked", 32'(o_locked), 32'd0);
    check("reset.bit_cnt", 32'(o_bit_cnt), 32'd0);

    // Continuous lock and 1000 locked bits.
    lock_up(n);
    check("lock.latency", 32'(n), 32'd25);
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      send(1'b1, 1'b0);
      if (o_err) pulses++;
    end
    check("cont.err_pulses", 32'(pulses), 32'd0);
    check("cont.bit_cnt", 32'(o_bit_cnt), 32'(exp_cnt(1000)));

    // Single line error.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      send(1'b1, i == 5);
      if (o_err) pulses++;
    end
    check("single.pulses", 32'(pulses), 32'd1);
    check("single.err_cnt", 32'(o_err_cnt), 32'(exp_cnt(1)));
    check("single.locked", 32'(o_locked), 32'd1);

    // Loss of lock: 8 errors at window positions 0..7.
    do_reset(1'b0);
    lock_up(n);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 1'b1);
      if (i == 6) check("loss.held7", 32'(o_locked), 32'd1);
    end
    check("loss.locked", 32'(o_locked), 32'd0);
    lock_up(n);
    check("relock.latency", 32'(n), 32'd25);
    check("relock.err_cnt", 32'(o_err_cnt), 32'(exp_cnt(8)));

    // 7 errors ending on window bit 64, then 7 in the next window.
    do_reset(1'b0);
    lock_up(n);
    for (int i = 0; i < 57; i++) send(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send(1'b1, 1'b1);
    check("b7.win1.locked", 32'(o_locked), 32'd1);
    for (int i = 0; i < 7; i++) send(1'b1, 1'b1);
    check("b7.win2.locked", 32'(o_locked), 32'd1);
    for (int i = 0; i < 20; i++) send(1'b1, 1'b0);

    // Dead line.
    do_reset(1'b0);
    for (int i = 0; i < 500; i++) drive(1'b0, 1'b1);
    check("dead.locked", 32'(o_locked), 32'd0);

    // Valid gaps 1-0-0-1: lock point counted in valid bits.
    do_reset(1'b0);
    n = 0; vcnt = 0;
    for (int k = 0; k < 200 && n == 0; k++) begin
      send((k % 4 == 0) || (k % 4 == 3), 1'b0);
      if ((k % 4 == 0) || (k % 4 == 3)) vcnt++;
      if (o_locked) n = vcnt;
    end
    check("gaps.latency", 32'(n), 32'd25);

    // Reset while locked.
    for (int i = 0; i < 10; i++) send(1'b1, 1'b0);
    do_reset(1'b1);
    check("midrst.locked", 32'(o_locked), 32'd0);
    check("midrst.bit_cnt", 32'(o_bit_cnt), 32'd0);
    check("midrst.err_cnt", 32'(o_err_cnt), 32'd0);
    lock_up(n);
    check("midrst.relock", 32'(n), 32'd25);

    // Randomized traffic: gaps, sparse and bursty errors, rare resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(999) == 0) do_reset(1'($urandom));
      else if (i >= 2000 && i < 2100) send(1'b1, $urandom_range(3) == 0);
      else send($urandom_range(3) != 0, $urandom_range(47) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs9_checker.md
# prbs9_checker

Receive-side counterpart of the `prbs9` generator: a self-synchronising PRBS9 checker (polynomial x^9 + x^5 + 1) that locks onto an incoming bit stream, flags per-bit errors and optionally accumulates bit/error counts for BER measurement. It sits after the QPSK demodulator/slicer, or directly on the `prbs9` output in loopback, and is seed-independent: any valid PRBS9 phase locks.

## Interface
- `LOCK_CNT`, 16: consecutive correct predictions in HUNT required to declare lock.
- `LOSS_WIN`, 64: length, in valid bits, of the loss-of-lock observation window.
- `LOSS_THR`, 8: errors within one window that force loss of lock (1 ≤ LOSS_THR ≤ LOSS_WIN).
- `CNT_W`, 32: width of the bit and error counters.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `i_bit`  in  1  received bit.
- `i_valid`  in  1  qualifies `i_bit`; when low, no state, register or counter changes.
- `o_locked`  out  1  high while in LOCKED.
- `o_err`  out  1  one-cycle pulse: a valid bit mismatched the prediction while LOCKED.
- `o_bit_cnt`  out  CNT_W  valid bits checked while LOCKED.
- `o_err_cnt`  out  CNT_W  errors counted while LOCKED.

## Operation
- 9-bit shift register `sr`. Prediction: `p = sr[8] ^ sr[4]`, i.e. bit[n] = bit[n-9] XOR bit[n-5]. Each valid bit shifts in at `sr[0]`.
- **FILL:** shift `i_bit` in on each valid bit. After 9 valid bits, go to HUNT with the match counter at 0.
- **HUNT:** on each valid bit, compare `i_bit` with `p`, then shift in `i_bit` (the received bit).
  - Match and `sr` ≠ 0: match counter +1.
  - Mismatch, or `sr` == 0: match counter clears to 0. This all-zero guard prevents locking on a dead line.
  - When the match counter reaches LOCK_CNT: go to LOCKED, and clear the window counter and window error counter.
- **LOCKED:** on each valid bit, shift in the predicted bit `p`, not `i_bit`, so one line error produces exactly one `o_err`.
  - Mismatch: `o_err` pulses and the window error counter increments.
  - The window counter increments on every valid bit.
  - At the end of a window (LOSS_WIN bits): if window errors, including the error on the closing bit, are ≥ LOSS_THR, go to FILL. Otherwise clear both window counters and stay in LOCKED.
  - If window errors reach LOSS_THR before the window ends, go to FILL immediately on that bit.
- Entering FILL from LOCKED: the fill counter restarts at 0. `o_bit_cnt` and `o_err_cnt` hold their values; only `rst` clears them.
- Counters saturate at 2^CNT_W−1 and never wrap.
- **Reset mid-operation:** the next clock returns the block to FILL with every counter at 0; no partial lock is retained.

## Timing
- Reset values: `o_locked`=0, `o_err`=0, `o_bit_cnt`=0, `o_err_cnt`=0, `sr`=0, state FILL.
- All outputs are registered. `o_err`, the counter updates and `o_locked` changes appear one cycle after the clock that samples the relevant valid bit.
- Minimum lock latency from reset release with continuous `i_valid`: 9 + LOCK_CNT valid bits. `o_locked` rises the cycle after bit 9 + LOCK_CNT is sampled (bit 25 with defaults).
- `o_locked` falls the cycle after the bit that triggers loss of lock is sampled.
- `i_valid` gaps of any length only stretch the timing; they never cause errors or state changes.

## Configuration
- `PRBS9_CHK_BER_CNT_EN` defined: `o_bit_cnt` and `o_err_cnt` are implemented as specified.
- Not defined: both counters are removed and the ports are tied to 0. `o_err`, `o_locked` and the state machine are unchanged.

## Structure
- Package `prbs9_pkg`:
  - state enum `{FILL, HUNT, LOCKED}`;
  - `PRBS9_LEN` = 9;
  - tap constants `PRBS9_TAP_A` = 8 and `PRBS9_TAP_B` = 4;
  - default values for LOCK_CNT, LOSS_WIN and LOSS_THR.
- One sub-module, `prbs9_err_window`: window counter plus window error counter with the threshold compare. It outputs a single `loss` strobe and takes a `clear` input.

## Test plan
- **Continuous lock:** `prbs9` output (SEED 9'b010101011) with `i_valid`=1 → `o_locked` rises the cycle after valid bit 25; `o_err` never pulses; `o_bit_cnt` = 1000 after 1000 locked bits.
- **Single error:** invert one bit after lock → exactly one `o_err` pulse; `o_err_cnt`=1; `o_locked` stays 1.
- **Loss of lock:** invert 8 bits inside one 64-bit window → `o_locked` falls the cycle after the 8th error. The block relocks after a further 25 clean bits, and `o_err_cnt`=8 is retained.
- **7-error boundary:** 7 errors in a window, the last on window bit 64 → lock is held and window counters clear. A further 7 in the next window → still locked.
- **Dead line and gaps:** all-zero input for 500 bits → `o_locked` stays 0. PRBS input with `i_valid` toggling 1-0-0-1 → same lock point, counted in valid bits.
- **Reset mid-lock:** assert `rst` for 1 cycle while locked → the next cycle shows `o_locked`=0 and both counters at 0; relock takes 25 bits.
